boot_loader: RTL and testbench

- Hardware image loader that runs the cpu core's state set-up in the opposite direction to the state-dump path: it writes, where the dump path reads.
- Accepts a 16-bit word stream with valid/ready handshake and decodes framed load records.
- Writes instruction memory, data memory and register-file contents, then releases the cpu from hold.
- Sits between a host/bench stream source and the cpu's memory and register write ports; owns the cpu hold signal.

---
 rtl/boot_loader_pkg.sv | 21 ++
 rtl/boot_loader.sv | 124 ++++++++++++
 tb/tb_boot_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: record word format, targets and FSM states.
// The bench stream generator uses the same word-format constants.
package boot_loader_pkg;

    localparam logic [1:0] TGT_IMEM = 2'b00;
    localparam logic [1:0] TGT_DMEM = 2'b01;
    localparam logic [1:0] TGT_RF   = 2'b10;
    localparam logic [1:0] TGT_GO   = 2'b11;

    localparam int TGT_MSB = 15;
    localparam int TGT_LSB = 14;
    localparam int CNT_W   = 14;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

endpackage

// File: rtl/boot_loader.sv
// Framed image loader: decodes header/address/data records from a word stream and
// writes imem, dmem and register file, then releases the cpu on a GO record.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int RF_ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic              rf_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [15:0]       words_written
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        tgt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] addr;
    logic              xfer;

    assign xfer = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next state gets a default first so no branch leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HDR: begin
                if (xfer) begin
                    state_nxt = (in_data[TGT_MSB:TGT_LSB] == TGT_GO) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (xfer) begin
                    state_nxt = (count == '0) ? ST_HDR : ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer && remaining == CNT_W'(1)) begin
                    state_nxt = ST_HDR;
                end
            end
            default: state_nxt = ST_DONE;
        endcase
    end

    // Handshake and cpu control are pure state decodes: no path from in_valid.
    always_comb begin
        in_ready  = (state != ST_DONE);
        cpu_hold  = (state != ST_DONE);
        load_done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt           <= TGT_IMEM;
            count         <= '0;
            remaining     <= '0;
            addr          <= '0;
            imem_we       <= 1'b0;
            dmem_we       <= 1'b0;
            rf_we         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            words_written <= '0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            rf_we   <= 1'b0;
            case (state)
                ST_HDR: begin
                    if (xfer) begin
                        tgt   <= in_data[TGT_MSB:TGT_LSB];
                        count <= in_data[CNT_W-1:0];
                    end
                end
                ST_ADDR: begin
                    if (xfer) begin
                        addr      <= in_data[ADDR_W-1:0];
                        remaining <= count;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        imem_we   <= (tgt == TGT_IMEM);
                        dmem_we   <= (tgt == TGT_DMEM);
                        rf_we     <= (tgt == TGT_RF);
                        // Register writes only see the low index bits, so they wrap 15 -> 0.
                        wr_addr   <= (tgt == TGT_RF) ?
                                     {{(ADDR_W-RF_ADDR_W){1'b0}}, addr[RF_ADDR_W-1:0]} : addr;
                        wr_data   <= in_data;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (words_written != 16'hFFFF) begin
                            words_written <= words_written + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed, table-driven bench for boot_loader: each vector drives one cycle of
// stream input and checks the registered outputs just after the following edge.
module tb_boot_loader;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic        dmem_we;
    logic        rf_we;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic [15:0] words_written;

    int checks = 0;
    int errors = 0;

    boot_loader #(.DATA_W(16), .ADDR_W(12), .RF_ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .dmem_we      (dmem_we),
        .rf_we        (rf_we),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // we field is {imem_we, dmem_we, rf_we}
    typedef struct {
        logic        rst;
        logic        valid;
        logic [15:0] data;
        logic        ready;
        logic [2:0]  we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic        hold;
        logic        done;
        logic [15:0] ww;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [15:0] d,
                                input logic rdy, input logic [2:0] we,
                                input logic [11:0] a, input logic [15:0] wd,
                                input logic h, input logic dn, input logic [15:0] ww);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.ready = rdy; t.we = we;
        t.addr = a; t.wdata = wd; t.hold = h; t.done = dn; t.ww = ww;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, check outputs 1 time unit after the rising edge.
    task automatic apply(input vec_t t, input int idx);
        string tag;
        @(negedge clk);
        rst      = t.rst;
        in_valid = t.valid;
        in_data  = t.data;
        @(posedge clk);
        #1;
        tag = $sformatf("v%0d", idx);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(t.ready));
        check({tag, ".strobes"}, 32'({imem_we, dmem_we, rf_we}), 32'(t.we));
        check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(t.hold));
        check({tag, ".load_done"}, 32'(load_done), 32'(t.done));
        check({tag, ".words_written"}, 32'(words_written), 32'(t.ww));
        if (t.we != 3'b000 || t.rst) begin
            check({tag, ".wr_addr"}, 32'(wr_addr), 32'(t.addr));
            check({tag, ".wr_data"}, 32'(wr_data), 32'(t.wdata));
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        repeat (2) @(posedge clk);

        // Reset state, then 5 idle cycles with nothing happening.
        apply(mk(1, 0, 16'h0000, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd0), 0);
        for (int i = 0; i < 5; i++) begin
            apply(mk(0, 0, 16'h0000, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd0), 100 + i);
        end

        // imem 3 words @0 back-to-back
        vecs.push_back(mk(0, 1, 16'h0003, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd0));
        vecs.push_back(mk(0, 1, 16'h0000, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd0));
        vecs.push_back(mk(0, 1, 16'h1A11, 1, 3'b100, 12'h000, 16'h1A11, 1, 0, 16'd1));
        vecs.push_back(mk(0, 1, 16'h2B22, 1, 3'b100, 12'h001, 16'h2B22, 1, 0, 16'd2));
        vecs.push_back(mk(0, 1, 16'h3C33, 1, 3'b100, 12'h002, 16'h3C33, 1, 0, 16'd3));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd3));
        // regfile 2 words @15, wraps to register 0
        vecs.push_back(mk(0, 1, 16'h8002, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd3));
        vecs.push_back(mk(0, 1, 16'h000F, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd3));
        vecs.push_back(mk(0, 1, 16'h0055, 1, 3'b001, 12'h00F, 16'h0055, 1, 0, 16'd4));
        vecs.push_back(mk(0, 1, 16'h0066, 1, 3'b001, 12'h000, 16'h0066, 1, 0, 16'd5));
        // dmem 2 words @0xFFF with a 2-cycle gap, address wraps to 0
        vecs.push_back(mk(0, 1, 16'h4002, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd5));
        vecs.push_back(mk(0, 1, 16'h0FFF, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd5));
        vecs.push_back(mk(0, 1, 16'hAAAA, 1, 3'b010, 12'hFFF, 16'hAAAA, 1, 0, 16'd6));
        vecs.push_back(mk(0, 0, 16'h1234, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd6));
        vecs.push_back(mk(0, 0, 16'h5678, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd6));
        vecs.push_back(mk(0, 1, 16'hBBBB, 1, 3'b010, 12'h000, 16'hBBBB, 1, 0, 16'd7));
        // empty dmem record: no writes, back to HDR
        vecs.push_back(mk(0, 1, 16'h4000, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd7));
        vecs.push_back(mk(0, 1, 16'h0010, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd7));
        // GO: accepted only if back in HDR; afterwards nothing is accepted
        vecs.push_back(mk(0, 1, 16'hC000, 0, 3'b000, 12'h000, 16'h0000, 0, 1, 16'd7));
        vecs.push_back(mk(0, 1, 16'h0001, 0, 3'b000, 12'h000, 16'h0000, 0, 1, 16'd7));
        vecs.push_back(mk(0, 1, 16'h0001, 0, 3'b000, 12'h000, 16'h0000, 0, 1, 16'd7));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i + 1);
        end

        // Reset out of DONE, then abandon an imem record mid-DATA with a reset.
        apply(mk(1, 0, 16'h0000, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd0), 200);
        apply(mk(0, 1, 16'h0004, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd0), 201);
        apply(mk(0, 1, 16'h0020, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd0), 202);
        apply(mk(0, 1, 16'h1111, 1, 3'b100, 12'h020, 16'h1111, 1, 0, 16'd1), 203);
        apply(mk(0, 1, 16'h2222, 1, 3'b100, 12'h021, 16'h2222, 1, 0, 16'd2), 204);
        apply(mk(1, 1, 16'h3333, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd0), 205);
        apply(mk(0, 0, 16'h4444, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd0), 206);
        // Fresh record from HDR: 0x5555 must be treated as data, not as the abandoned record's tail.
        apply(mk(0, 1, 16'h4001, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd0), 207);
        apply(mk(0, 1, 16'h0100, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd0), 208);
        apply(mk(0, 1, 16'h5555, 1, 3'b010, 12'h100, 16'h5555, 1, 0, 16'd1), 209);
        apply(mk(0, 0, 16'h0000, 1, 3'b000, 12'h000, 16'h0000, 1, 0, 16'd1), 210);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
